ws2812b_axil_regs: RTL

- AXI4-Lite responder (slave) that terminates the bus master's register traffic for the WS2812B pixel-driver IP.
- Holds four 32-bit read/write registers and presents them to the pixel engine as parallel outputs.
- Generates a one-cycle start strobe for the engine.
- Sits between the AXI interconnect (S00_AXI) and the WS2812B bit-timing core.

---
 rtl/ws2812b_pkg.sv | 38 +++
 rtl/ws2812b_axil_wr_ctrl.sv | 85 ++++++++
 rtl/ws2812b_axil_regs.sv | 122 ++++++++++++
 3 files changed

// File: rtl/ws2812b_pkg.sv
// Shared definitions for the WS2812B AXI4-Lite register block.
// Register map indices, control bit positions and write-channel states.
package ws2812b_pkg;

    localparam logic [1:0] REG_CTRL  = 2'd0;
    localparam logic [1:0] REG_COLOR = 2'd1;
    localparam logic [1:0] REG_COUNT = 2'd2;
    localparam logic [1:0] REG_AUX   = 2'd3;

    localparam int CTRL_START_BIT = 0;
    localparam int CTRL_EN_BIT    = 1;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [2:0] {
        W_IDLE,
        W_HAVE_ADDR,
        W_HAVE_DATA,
        W_COMMIT,
        W_RESP
    } wr_state_e;

    function automatic logic [31:0] apply_strb(
        input logic [31:0] old_val,
        input logic [31:0] new_val,
        input logic [3:0]  strb
    );
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ws2812b_axil_wr_ctrl.sv
// AXI4-Lite write-channel controller: independent AW/W capture,
// a one-cycle commit strobe toward the register file, then the B response.
module ws2812b_axil_wr_ctrl
    import ws2812b_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en_i,
    input  logic [3:0]  awaddr_i,
    input  logic        awvalid_i,
    output logic        awready_o,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  wstrb_i,
    input  logic        wvalid_i,
    output logic        wready_o,
    output logic        bvalid_o,
    input  logic        bready_i,
    output logic        wr_en_o,
    output logic [1:0]  wr_idx_o,
    output logic [31:0] wr_data_o,
    output logic [3:0]  wr_strb_o
);

    wr_state_e   state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] data_q, data_d;
    logic [3:0]  strb_q, strb_d;
    logic        aw_hs, w_hs;
    logic        unused_addr;

    assign unused_addr = ^awaddr_i[1:0];

    always_comb begin
        awready_o = en_i && (state_q == W_IDLE || state_q == W_HAVE_DATA);
        wready_o  = en_i && (state_q == W_IDLE || state_q == W_HAVE_ADDR);
        aw_hs     = awvalid_i && awready_o;
        w_hs      = wvalid_i && wready_o;
        bvalid_o  = (state_q == W_RESP);
        wr_en_o   = (state_q == W_COMMIT);
        wr_idx_o  = idx_q;
        wr_data_o = data_q;
        wr_strb_o = strb_q;
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        strb_d  = strb_q;
        if (aw_hs) begin
            idx_d = awaddr_i[3:2];
        end
        if (w_hs) begin
            data_d = wdata_i;
            strb_d = wstrb_i;
        end
        unique case (state_q)
            W_IDLE: begin
                if (aw_hs && w_hs) state_d = W_COMMIT;
                else if (aw_hs)    state_d = W_HAVE_ADDR;
                else if (w_hs)     state_d = W_HAVE_DATA;
            end
            W_HAVE_ADDR: if (w_hs)  state_d = W_COMMIT;
            W_HAVE_DATA: if (aw_hs) state_d = W_COMMIT;
            W_COMMIT:    state_d = W_RESP;
            W_RESP:      if (bready_i) state_d = W_IDLE;
            default:     state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= W_IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            strb_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            strb_q  <= strb_d;
        end
    end

endmodule

// File: rtl/ws2812b_axil_regs.sv
// AXI4-Lite register block for the WS2812B pixel driver: four R/W
// registers exposed in parallel plus a one-cycle engine start strobe.
module ws2812b_axil_regs
    import ws2812b_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   AWADDR,
    input  logic [2:0]                      AWPROT,
    input  logic                            AWVALID,
    output logic                            AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] WSTRB,
    input  logic                            WVALID,
    output logic                            WREADY,
    output logic [1:0]                      BRESP,
    output logic                            BVALID,
    input  logic                            BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   ARADDR,
    input  logic [2:0]                      ARPROT,
    input  logic                            ARVALID,
    output logic                            ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]                      RRESP,
    output logic                            RVALID,
    input  logic                            RREADY,
    output logic [31:0]                     ctrl_o,
    output logic [31:0]                     color_o,
    output logic [31:0]                     led_count_o,
    output logic [31:0]                     aux_o,
    output logic                            start_o
);

    logic [31:0] regs_q [4];
    logic [31:0] regs_d [4];
    logic [31:0] rdata_q, rdata_d;
    logic        rvalid_q, rvalid_d;
    logic        start_q, start_d;
    logic        active_q, active_d;
    logic        ar_hs;
    logic        wr_en;
    logic [1:0]  wr_idx;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic        unused_prot;

    assign unused_prot = ^{AWPROT, ARPROT, ARADDR[1:0]};

    ws2812b_axil_wr_ctrl u_wr_ctrl (
        .clk       (ACLK),
        .rst       (ARESET),
        .en_i      (active_q),
        .awaddr_i  (AWADDR),
        .awvalid_i (AWVALID),
        .awready_o (AWREADY),
        .wdata_i   (WDATA),
        .wstrb_i   (WSTRB),
        .wvalid_i  (WVALID),
        .wready_o  (WREADY),
        .bvalid_o  (BVALID),
        .bready_i  (BREADY),
        .wr_en_o   (wr_en),
        .wr_idx_o  (wr_idx),
        .wr_data_o (wr_data),
        .wr_strb_o (wr_strb)
    );

    always_comb begin
        ARREADY = active_q && !rvalid_q;
        ar_hs   = ARVALID && ARREADY;
        BRESP   = RESP_OKAY;
        RRESP   = RESP_OKAY;
        RDATA   = rdata_q;
        RVALID  = rvalid_q;
        start_o = start_q;
        ctrl_o      = regs_q[REG_CTRL];
        color_o     = regs_q[REG_COLOR];
        led_count_o = regs_q[REG_COUNT];
        aux_o       = regs_q[REG_AUX];
    end

    // Reads sample regs_q, so a same-edge write is seen only by later reads.
    always_comb begin
        active_d = 1'b1;
        regs_d   = regs_q;
        rdata_d  = rdata_q;
        rvalid_d = rvalid_q;
        start_d  = 1'b0;
        if (wr_en) begin
            regs_d[wr_idx] = apply_strb(regs_q[wr_idx], wr_data, wr_strb);
            start_d = (wr_idx == REG_CTRL) && wr_strb[0]
                   && wr_data[CTRL_START_BIT];
        end
        if (rvalid_q && RREADY) begin
            rvalid_d = 1'b0;
        end
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = regs_q[ARADDR[3:2]];
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            regs_q   <= '{default: '0};
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            start_q  <= 1'b0;
            active_q <= 1'b0;
        end else begin
            regs_q   <= regs_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            start_q  <= start_d;
            active_q <= active_d;
        end
    end

endmodule
